// File: rtl/reg_scoreboard_pkg.sv
// Shared definitions for the pending-write scoreboard.
//   ADDRESS_SIZE_DEF : default register index width
//   MAX_INFLIGHT_DEF : default maximum outstanding writes per register
//   reg_idx_t        : register index at the default width
//   clog2_f          : counter/sum width helper (never returns less than 1)
package reg_scoreboard_pkg;

    localparam int ADDRESS_SIZE_DEF = 4;
    localparam int MAX_INFLIGHT_DEF = 3;

    typedef logic [ADDRESS_SIZE_DEF-1:0] reg_idx_t;

    // Width needed to hold values 0..value-1; a width of 0 is not allowed
    function automatic int clog2_f(input int value);
        if (value <= 1) begin
            return 1;
        end else begin
            return $clog2(value);
        end
    endfunction

endpackage

// File: rtl/reg_scoreboard_entry.sv
// One scoreboard counter: outstanding writes to a single architectural register.
// Ports:
//   clk, rst   : clock, synchronous active-low reset
//   inc, dec   : issue of a write / retirement of a write this cycle
//   cnt_next   : count after this cycle's update (used by the top for sums/mask)
//   eff_busy   : register is busy for a reader in ID this cycle
//   ovf, unf   : single-cycle error events (saturation / retire with zero count)
module scoreboard_entry
    import reg_scoreboard_pkg::*;
#(
    parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
    parameter int WB_BYPASS    = 1,
    localparam int CNTW        = clog2_f(MAX_INFLIGHT + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    input  logic            dec,
    output logic [CNTW-1:0] cnt_next,
    output logic            eff_busy,
    output logic            ovf,
    output logic            unf
);

    localparam logic [CNTW-1:0] ZERO_CNT = {CNTW{1'b0}};
    localparam logic [CNTW-1:0] ONE_CNT  = CNTW'(1'b1);
    localparam logic [CNTW-1:0] MAX_CNT  = CNTW'(MAX_INFLIGHT);
    localparam logic            BYPASS   = (WB_BYPASS != 0);

    logic [CNTW-1:0] cnt_r;
    logic [CNTW-1:0] cnt_next_s;
    logic            ovf_s;
    logic            unf_s;

    // Next count with saturation at both ends and error event generation
    always_comb begin
        cnt_next_s = cnt_r;
        ovf_s      = 1'b0;
        unf_s      = 1'b0;
        case ({inc, dec})
            2'b11: begin
                // A retire with nothing outstanding is bogus; keep the new issue
                if (cnt_r == ZERO_CNT) begin
                    unf_s      = 1'b1;
                    cnt_next_s = ONE_CNT;
                end else begin
                    cnt_next_s = cnt_r;
                end
            end
            2'b10: begin
                if (cnt_r == MAX_CNT) begin
                    ovf_s      = 1'b1;
                    cnt_next_s = cnt_r;
                end else begin
                    cnt_next_s = cnt_r + ONE_CNT;
                end
            end
            2'b01: begin
                if (cnt_r == ZERO_CNT) begin
                    unf_s      = 1'b1;
                    cnt_next_s = cnt_r;
                end else begin
                    cnt_next_s = cnt_r - ONE_CNT;
                end
            end
            default: begin
                cnt_next_s = cnt_r;
            end
        endcase
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r <= ZERO_CNT;
        end else begin
            cnt_r <= cnt_next_s;
        end
    end

    // The last outstanding write retiring now is already in the register file
    // when bypass is enabled, so it does not block the reader.
    assign eff_busy = (cnt_r != ZERO_CNT) & ~(BYPASS & dec & (cnt_r == ONE_CNT));
    assign cnt_next = cnt_next_s;
    assign ovf      = ovf_s;
    assign unf      = unf_s;

endmodule

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard beside the register file in ID.
// Stalls an ID instruction whose sources still have writes in flight and
// retires entries from the register-file write-back port.
// Ports:
//   clk, rst              : clock, synchronous active-low reset
//   src1, src2, two_src   : ID source registers; src2 checked only with two_src
//   id_valid, id_wb_en,
//   id_dest               : ID instruction presence and its destination
//   freeze                : external stall, blocks issue
//   writeBackEn, Dest_wb  : write-back strobe and destination
//   hazard, issue         : combinational stall / issue indications
//   busy_mask, pending    : registered per-register busy bits and total count
//   overflow_err,
//   underflow_err         : sticky debug error flags
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int ADDRESS_SIZE = ADDRESS_SIZE_DEF,
    parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
    parameter int WB_BYPASS    = 1,
    localparam int NREG        = 2 ** ADDRESS_SIZE,
    localparam int CNTW        = clog2_f(MAX_INFLIGHT + 1),
    localparam int CW          = clog2_f(MAX_INFLIGHT * NREG + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDRESS_SIZE-1:0] src1,
    input  logic [ADDRESS_SIZE-1:0] src2,
    input  logic                    two_src,
    input  logic                    id_valid,
    input  logic                    id_wb_en,
    input  logic [ADDRESS_SIZE-1:0] id_dest,
    input  logic                    freeze,
    input  logic                    writeBackEn,
    input  logic [ADDRESS_SIZE-1:0] Dest_wb,
    output logic                    hazard,
    output logic                    issue,
    output logic [NREG-1:0]         busy_mask,
    output logic [CW-1:0]           pending,
    output logic                    overflow_err,
    output logic                    underflow_err
);

    logic [NREG-1:0] inc_s;
    logic [NREG-1:0] dec_s;
    logic [NREG-1:0] eb_s;
    logic [NREG-1:0] ovf_evt_s;
    logic [NREG-1:0] unf_evt_s;
    logic [CNTW-1:0] cnt_next_s [NREG];
    logic [NREG-1:0] busy_next_s;
    logic [CW-1:0]   pending_next_s;
    logic            hazard_s;
    logic            issue_s;

    logic [NREG-1:0] busy_mask_r;
    logic [CW-1:0]   pending_r;
    logic            overflow_err_r;
    logic            underflow_err_r;

    // Hazard looks only at older writes (current counts); the ID instruction's
    // own destination enters the counters through inc and cannot stall itself.
    assign hazard_s = id_valid & (eb_s[src1] | (two_src & eb_s[src2]));
    assign issue_s  = id_valid & ~hazard_s & ~freeze;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_entry
            assign inc_s[gi] = issue_s & id_wb_en & (id_dest == ADDRESS_SIZE'(gi));
            assign dec_s[gi] = writeBackEn & (Dest_wb == ADDRESS_SIZE'(gi));

            scoreboard_entry #(
                .MAX_INFLIGHT (MAX_INFLIGHT),
                .WB_BYPASS    (WB_BYPASS)
            ) u_entry (
                .clk      (clk),
                .rst      (rst),
                .inc      (inc_s[gi]),
                .dec      (dec_s[gi]),
                .cnt_next (cnt_next_s[gi]),
                .eff_busy (eb_s[gi]),
                .ovf      (ovf_evt_s[gi]),
                .unf      (unf_evt_s[gi])
            );
        end
    endgenerate

    // Busy bits and total outstanding count derived from the post-update counts
    always_comb begin
        busy_next_s    = {NREG{1'b0}};
        pending_next_s = {CW{1'b0}};
        for (int i = 0; i < NREG; i++) begin
            busy_next_s[i] = (cnt_next_s[i] != {CNTW{1'b0}});
            pending_next_s = pending_next_s + CW'(cnt_next_s[i]);
        end
    end

    // Registered status outputs; error flags hold until reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_mask_r     <= {NREG{1'b0}};
            pending_r       <= {CW{1'b0}};
            overflow_err_r  <= 1'b0;
            underflow_err_r <= 1'b0;
        end else begin
            busy_mask_r     <= busy_next_s;
            pending_r       <= pending_next_s;
            overflow_err_r  <= overflow_err_r | (|ovf_evt_s);
            underflow_err_r <= underflow_err_r | (|unf_evt_s);
        end
    end

    assign hazard        = hazard_s;
    assign issue         = issue_s;
    assign busy_mask     = busy_mask_r;
    assign pending       = pending_r;
    assign overflow_err  = overflow_err_r;
    assign underflow_err = underflow_err_r;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard-style bench for reg_scoreboard (default parameters:
// 16 registers, MAX_INFLIGHT=3, WB_BYPASS=1). Stimulus pushes expected
// values tagged with the cycle they must be observed in; a monitor on the
// falling edge pops and compares them.
module tb_reg_scoreboard;
    import reg_scoreboard_pkg::*;

    localparam int NREG = 16;
    localparam int CW   = 6;

    localparam int K_HAZ  = 0;
    localparam int K_ISS  = 1;
    localparam int K_BUSY = 2;
    localparam int K_PEND = 3;
    localparam int K_OVF  = 4;
    localparam int K_UNF  = 5;

    typedef struct {
        string       name;
        int          cyc;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    reg_idx_t        src1, src2, id_dest, Dest_wb;
    logic            two_src, id_valid, id_wb_en, freeze, writeBackEn;
    logic            hazard, issue, overflow_err, underflow_err;
    logic [NREG-1:0] busy_mask;
    logic [CW-1:0]   pending;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    reg_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .src1         (src1),
        .src2         (src2),
        .two_src      (two_src),
        .id_valid     (id_valid),
        .id_wb_en     (id_wb_en),
        .id_dest      (id_dest),
        .freeze       (freeze),
        .writeBackEn  (writeBackEn),
        .Dest_wb      (Dest_wb),
        .hazard       (hazard),
        .issue        (issue),
        .busy_mask    (busy_mask),
        .pending      (pending),
        .overflow_err (overflow_err),
        .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation due in the current cycle
    always @(negedge clk) begin
        logic [31:0] act;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc <= cyc) begin
                case (q[i].kind)
                    K_HAZ:   act = {31'd0, hazard};
                    K_ISS:   act = {31'd0, issue};
                    K_BUSY:  act = {16'd0, busy_mask};
                    K_PEND:  act = {26'd0, pending};
                    K_OVF:   act = {31'd0, overflow_err};
                    K_UNF:   act = {31'd0, underflow_err};
                    default: act = 32'hFFFF_FFFF;
                endcase
                checks++;
                if (q[i].cyc < cyc) begin
                    failures++;
                    $display("FAIL %s: expectation for cycle %0d missed at cycle %0d",
                             q[i].name, q[i].cyc, cyc);
                end else if (act !== q[i].exp) begin
                    failures++;
                    $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                             q[i].name, act, q[i].exp, cyc);
                end
                q.delete(i);
            end
        end
    end

    task automatic expect_v(input string nm, input int kind, input logic [31:0] v,
                            input int dly);
        exp_t e;
        e.name = nm;
        e.cyc  = cyc + dly;
        e.kind = kind;
        e.exp  = v;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        src1 = 4'd0; src2 = 4'd0; two_src = 1'b0; id_valid = 1'b0;
        id_wb_en = 1'b0; id_dest = 4'd0; freeze = 1'b0;
        writeBackEn = 1'b0; Dest_wb = 4'd0;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        step();
        step();
        rst = 1'b1;

        // Reset state
        id_valid = 1'b1; src1 = 4'd2;
        expect_v("rst_hazard", K_HAZ, 32'd0, 0);
        expect_v("rst_issue", K_ISS, 32'd1, 0);
        expect_v("rst_busy", K_BUSY, 32'd0, 0);
        expect_v("rst_pending", K_PEND, 32'd0, 0);
        expect_v("rst_ovf", K_OVF, 32'd0, 0);
        expect_v("rst_unf", K_UNF, 32'd0, 0);
        step();

        // R2 producer then dependent reader
        id_wb_en = 1'b1; id_dest = 4'd2; src1 = 4'd0;
        expect_v("r2_issue", K_ISS, 32'd1, 0);
        expect_v("r2_busy", K_BUSY, 32'h4, 1);
        expect_v("r2_pending", K_PEND, 32'd1, 1);
        step();
        id_wb_en = 1'b0; src1 = 4'd2;
        expect_v("rd_hazard", K_HAZ, 32'd1, 0);
        expect_v("rd_issue", K_ISS, 32'd0, 0);
        step();
        expect_v("rd_hazard2", K_HAZ, 32'd1, 0);
        expect_v("rd_busy2", K_BUSY, 32'h4, 0);
        step();
        writeBackEn = 1'b1; Dest_wb = 4'd2;
        expect_v("byp_hazard", K_HAZ, 32'd0, 0);
        expect_v("byp_issue", K_ISS, 32'd1, 0);
        expect_v("byp_busy", K_BUSY, 32'd0, 1);
        expect_v("byp_pending", K_PEND, 32'd0, 1);
        expect_v("byp_unf", K_UNF, 32'd0, 1);
        step();

        // R5 saturation
        writeBackEn = 1'b0;
        id_valid = 1'b1; id_wb_en = 1'b1; id_dest = 4'd5; src1 = 4'd0;
        for (int i = 0; i < 3; i++) step();
        expect_v("r5_pre_ovf", K_OVF, 32'd0, 0);
        expect_v("r5_pre_pending", K_PEND, 32'd3, 0);
        expect_v("r5_issue4", K_ISS, 32'd1, 0);
        expect_v("r5_ovf", K_OVF, 32'd1, 1);
        expect_v("r5_pending", K_PEND, 32'd3, 1);
        expect_v("r5_busy", K_BUSY, 32'h20, 1);
        step();
        id_valid = 1'b0; id_wb_en = 1'b0;
        writeBackEn = 1'b1; Dest_wb = 4'd5;
        for (int i = 0; i < 3; i++) step();
        writeBackEn = 1'b0;
        expect_v("r5_drain_pending", K_PEND, 32'd0, 0);
        expect_v("r5_drain_busy", K_BUSY, 32'd0, 0);
        expect_v("ovf_sticky", K_OVF, 32'd1, 0);
        expect_v("r5_drain_unf", K_UNF, 32'd0, 0);

        // R3 simultaneous issue and retire with cnt=1
        id_valid = 1'b1; id_wb_en = 1'b1; id_dest = 4'd3;
        step();
        writeBackEn = 1'b1; Dest_wb = 4'd3;
        expect_v("r3_issue", K_ISS, 32'd1, 0);
        expect_v("r3_busy", K_BUSY, 32'h8, 1);
        expect_v("r3_pending", K_PEND, 32'd1, 1);
        expect_v("r3_unf", K_UNF, 32'd0, 1);
        step();
        id_valid = 1'b0; id_wb_en = 1'b0;
        step();
        writeBackEn = 1'b0;
        expect_v("r3_drain_pending", K_PEND, 32'd0, 0);

        // Underflow on R7 with R1 busy
        id_valid = 1'b1; id_wb_en = 1'b1; id_dest = 4'd1;
        step();
        id_valid = 1'b0; id_wb_en = 1'b0;
        writeBackEn = 1'b1; Dest_wb = 4'd7;
        expect_v("r7_pre_unf", K_UNF, 32'd0, 0);
        expect_v("r7_unf", K_UNF, 32'd1, 1);
        expect_v("r7_busy", K_BUSY, 32'h2, 1);
        expect_v("r7_pending", K_PEND, 32'd1, 1);
        step();
        writeBackEn = 1'b0;

        // src2 gating by two_src (R1 busy, R0 free)
        id_valid = 1'b1; src1 = 4'd0; src2 = 4'd1; two_src = 1'b0;
        expect_v("src2_off_hazard", K_HAZ, 32'd0, 0);
        expect_v("src2_off_issue", K_ISS, 32'd1, 0);
        step();
        two_src = 1'b1;
        expect_v("src2_on_hazard", K_HAZ, 32'd1, 0);
        expect_v("src2_on_issue", K_ISS, 32'd0, 0);
        step();
        id_valid = 1'b0; two_src = 1'b0;
        writeBackEn = 1'b1; Dest_wb = 4'd1;
        step();
        writeBackEn = 1'b0;
        expect_v("r1_drain_pending", K_PEND, 32'd0, 0);

        // Freeze blocks issue
        id_valid = 1'b1; id_wb_en = 1'b1; id_dest = 4'd4; freeze = 1'b1;
        expect_v("frz_issue", K_ISS, 32'd0, 0);
        expect_v("frz_hazard", K_HAZ, 32'd0, 0);
        expect_v("frz_busy", K_BUSY, 32'd0, 1);
        expect_v("frz_pending", K_PEND, 32'd0, 1);
        step();
        freeze = 1'b0;
        step();
        id_dest = 4'd6;
        step();
        id_dest = 4'd8;
        step();
        id_dest = 4'd9;
        step();
        id_valid = 1'b0; id_wb_en = 1'b0;
        expect_v("pre_rst_pending", K_PEND, 32'd4, 0);
        expect_v("pre_rst_busy", K_BUSY, 32'h350, 0);
        expect_v("pre_rst_unf", K_UNF, 32'd1, 0);

        // Reset mid-operation
        rst = 1'b0;
        step();
        rst = 1'b1;
        id_valid = 1'b1; src1 = 4'd4;
        expect_v("mrst_busy", K_BUSY, 32'd0, 0);
        expect_v("mrst_pending", K_PEND, 32'd0, 0);
        expect_v("mrst_ovf", K_OVF, 32'd0, 0);
        expect_v("mrst_unf", K_UNF, 32'd0, 0);
        expect_v("mrst_hazard", K_HAZ, 32'd0, 0);
        expect_v("mrst_issue", K_ISS, 32'd1, 0);
        step();
        idle();

        // Drain the expectation queue within a bounded number of cycles
        for (int i = 0; i < 5 && q.size() != 0; i++) step();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
